// File: rtl/mem_bus_ctrl.sv
// rtl/mem_bus_ctrl.sv - core-to-memory handshake controller with programmable latency and debug write priority
//
// Purpose:
//   Accepts single-cycle core read/write requests while idle. The request is
//   latched and then held for LATENCY cycles before the memory access. Completion
//   is signalled by a one-cycle core_ack. The debug write port always owns the
//   memory write port. A core write that is ready to commit while dbg_wen is high
//   waits until dbg_wen drops.
//
// Ports:
//   clk, rst          clock and synchronous active-low reset
//   core_rd_req       read request, sampled only while idle
//   core_wr_req       write request, sampled only while idle (wins over read)
//   core_addr         request address
//   core_wr_data      request write data
//   core_rd_data      registered read result, held until the next read completes
//   core_ack          one-cycle completion pulse
//   core_busy         high while a request is in flight
//   dbg_wen           debug write enable
//   dbg_write_addr    debug write address
//   dbg_write_data    debug write data
//   mem_read_addr     memory read address (latched request address)
//   mem_read_data     memory read data (combinational read port)
//   mem_write_addr    memory write address
//   mem_write_data    memory write data
//   mem_wen           memory write enable
//   stat_reads/stat_writes/stat_stalls
//                     saturating activity counters, present only when
//                     MEM_BUS_CTRL_STATS_EN is defined

module mem_bus_ctrl #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int LATENCY = 2,
    parameter int CNT_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              core_rd_req,
    input  logic              core_wr_req,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wr_data,
    output logic [DATA_W-1:0] core_rd_data,
    output logic              core_ack,
    output logic              core_busy,
    input  logic              dbg_wen,
    input  logic [ADDR_W-1:0] dbg_write_addr,
    input  logic [DATA_W-1:0] dbg_write_data,
    output logic [ADDR_W-1:0] mem_read_addr,
    input  logic [DATA_W-1:0] mem_read_data,
    output logic [ADDR_W-1:0] mem_write_addr,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_wen
`ifdef MEM_BUS_CTRL_STATS_EN
    ,
    output logic [15:0]       stat_reads,
    output logic [15:0]       stat_writes,
    output logic [15:0]       stat_stalls
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   lat_addr_q, lat_addr_d;
    logic [DATA_W-1:0]   lat_data_q, lat_data_d;
    logic                lat_is_wr_q, lat_is_wr_d;
    logic [DATA_W-1:0]   rd_data_q, rd_data_d;

    logic                access_due;
    logic                wr_commit;
    logic                wr_stall;

    // Latency has expired; the latched request touches memory this cycle.
    assign access_due = (state_q == S_WAIT) && (cnt_q == '0);
    assign wr_commit  = access_due && lat_is_wr_q && !dbg_wen;
    assign wr_stall   = access_due && lat_is_wr_q && dbg_wen;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        lat_addr_d  = lat_addr_q;
        lat_data_d  = lat_data_q;
        lat_is_wr_d = lat_is_wr_q;
        rd_data_d   = rd_data_q;
        case (state_q)
            S_IDLE: begin
                if (core_wr_req || core_rd_req) begin
                    lat_addr_d  = core_addr;
                    lat_data_d  = core_wr_data;
                    lat_is_wr_d = core_wr_req;
                    cnt_d       = CNT_W'(LATENCY - 1);
                    state_d     = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (!lat_is_wr_q) begin
                    // Captured before any same-cycle debug write lands.
                    rd_data_d = mem_read_data;
                    state_d   = S_DONE;
                end else if (!dbg_wen) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            lat_addr_q  <= '0;
            lat_data_q  <= '0;
            lat_is_wr_q <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            lat_addr_q  <= lat_addr_d;
            lat_data_q  <= lat_data_d;
            lat_is_wr_q <= lat_is_wr_d;
            rd_data_q   <= rd_data_d;
        end
    end

    // Gating with rst keeps the core-side outputs quiet for the whole reset
    // cycle. This covers a reset that arrives mid-transaction.
    assign core_ack       = rst && (state_q == S_DONE);
    assign core_busy      = rst && (state_q != S_IDLE);
    assign core_rd_data   = rd_data_q;
    assign mem_read_addr  = lat_addr_q;
    assign mem_write_addr = dbg_wen ? dbg_write_addr : lat_addr_q;
    assign mem_write_data = dbg_wen ? dbg_write_data : lat_data_q;
    assign mem_wen        = dbg_wen || (rst && wr_commit);

`ifdef MEM_BUS_CTRL_STATS_EN
    logic [15:0] stat_reads_q, stat_writes_q, stat_stalls_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            stat_reads_q  <= '0;
            stat_writes_q <= '0;
            stat_stalls_q <= '0;
        end else begin
            if (state_q == S_DONE && !lat_is_wr_q && stat_reads_q != 16'hFFFF)
                stat_reads_q <= stat_reads_q + 16'd1;
            if (state_q == S_DONE && lat_is_wr_q && stat_writes_q != 16'hFFFF)
                stat_writes_q <= stat_writes_q + 16'd1;
            if (wr_stall && stat_stalls_q != 16'hFFFF)
                stat_stalls_q <= stat_stalls_q + 16'd1;
        end
    end

    assign stat_reads  = stat_reads_q;
    assign stat_writes = stat_writes_q;
    assign stat_stalls = stat_stalls_q;
`else
    logic unused_stall;
    assign unused_stall = wr_stall;
`endif

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// tb/tb_mem_bus_ctrl.sv - directed self-checking bench for mem_bus_ctrl

module tb_mem_bus_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       core_rd_req, core_wr_req;
    logic [7:0] core_addr, core_wr_data, core_rd_data;
    logic       core_ack, core_busy;
    logic       dbg_wen;
    logic [7:0] dbg_write_addr, dbg_write_data;
    logic [7:0] mem_read_addr, mem_read_data;
    logic [7:0] mem_write_addr, mem_write_data;
    logic       mem_wen;
`ifdef MEM_BUS_CTRL_STATS_EN
    logic [15:0] stat_reads, stat_writes, stat_stalls;
`endif

    logic [7:0] mem [256];
    logic       tb_clr;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    assign mem_read_data = mem[mem_read_addr];

    always @(posedge clk) begin
        if (tb_clr) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
        end else if (mem_wen) begin
            mem[mem_write_addr] <= mem_write_data;
        end
    end

    mem_bus_ctrl #(.ADDR_W(8), .DATA_W(8), .LATENCY(2), .CNT_W(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .core_rd_req    (core_rd_req),
        .core_wr_req    (core_wr_req),
        .core_addr      (core_addr),
        .core_wr_data   (core_wr_data),
        .core_rd_data   (core_rd_data),
        .core_ack       (core_ack),
        .core_busy      (core_busy),
        .dbg_wen        (dbg_wen),
        .dbg_write_addr (dbg_write_addr),
        .dbg_write_data (dbg_write_data),
        .mem_read_addr  (mem_read_addr),
        .mem_read_data  (mem_read_data),
        .mem_write_addr (mem_write_addr),
        .mem_write_data (mem_write_data),
        .mem_wen        (mem_wen)
`ifdef MEM_BUS_CTRL_STATS_EN
        ,
        .stat_reads     (stat_reads),
        .stat_writes    (stat_writes),
        .stat_stalls    (stat_stalls)
`endif
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issues one request in cycle 0 and observes cycles 0..9.
    // A cycle index of -1 means the event was never seen.
    task automatic run_req(input logic rd, input logic wr, input logic [7:0] addr,
                           input logic [7:0] data, input logic again,
                           output int ack_at, output int wen_at, output int acks,
                           output logic [9:0] busy_mask);
        ack_at = -1;
        wen_at = -1;
        acks = 0;
        busy_mask = '0;
        core_rd_req = rd;
        core_wr_req = wr;
        core_addr = addr;
        core_wr_data = data;
        for (int k = 0; k < 10; k++) begin
            if (k > 0) begin
                cyc();
                core_rd_req = 1'b0;
                core_wr_req = 1'b0;
                if (again && k == 1) begin
                    core_rd_req = 1'b1;
                    core_addr = 8'd6;
                end
            end
            #1;
            busy_mask[k] = core_busy;
            if (core_ack) begin
                acks++;
                if (ack_at < 0) ack_at = k;
            end
            if (mem_wen && wen_at < 0) wen_at = k;
        end
    endtask

    int         ack_at, wen_at, acks;
    logic [9:0] busy_mask;

    initial begin
        rst = 1'b0;
        tb_clr = 1'b1;
        core_rd_req = 1'b0;
        core_wr_req = 1'b0;
        core_addr = 8'h00;
        core_wr_data = 8'h00;
        dbg_wen = 1'b1;
        dbg_write_addr = 8'd3;
        dbg_write_data = 8'h44;
        cyc();
        cyc();
        chk("reset_ack", core_ack, 0);
        chk("reset_busy", core_busy, 0);
        chk("reset_rd_data", core_rd_data, 0);
        chk("reset_wen_follows_dbg_hi", mem_wen, 1);
        dbg_wen = 1'b0;
        #1;
        chk("reset_wen_follows_dbg_lo", mem_wen, 0);
        tb_clr = 1'b0;
        rst = 1'b1;
        cyc();

        // Debug preload: mem[i] = i + 3
        for (int i = 0; i < 8; i++) begin
            dbg_wen = 1'b1;
            dbg_write_addr = 8'(i);
            dbg_write_data = 8'(i + 3);
            #1;
            chk("preload_wen", mem_wen, 1);
            chk("preload_busy", core_busy, 0);
            cyc();
        end
        dbg_wen = 1'b0;

        // Core read of addr 5
        run_req(1'b1, 1'b0, 8'd5, 8'd0, 1'b0, ack_at, wen_at, acks, busy_mask);
        chk("rd5_ack_cycle", ack_at, 3);
        chk("rd5_ack_count", acks, 1);
        chk("rd5_no_wen", wen_at, -1);
        chk("rd5_busy_mask", 32'(busy_mask), 32'h00E);
        chk("rd5_data", core_rd_data, 8);

        // Core write addr 10 = 5, then read it back
        run_req(1'b0, 1'b1, 8'd10, 8'd5, 1'b0, ack_at, wen_at, acks, busy_mask);
        chk("wr10_ack_cycle", ack_at, 3);
        chk("wr10_wen_cycle", wen_at, 2);
        chk("wr10_ack_count", acks, 1);
        chk("wr10_rd_data_kept", core_rd_data, 8);
        run_req(1'b1, 1'b0, 8'd10, 8'd0, 1'b0, ack_at, wen_at, acks, busy_mask);
        chk("rd10_ack_cycle", ack_at, 3);
        chk("rd10_data", core_rd_data, 5);

        // Dual request: write wins, read result untouched
        run_req(1'b1, 1'b1, 8'd12, 8'd9, 1'b0, ack_at, wen_at, acks, busy_mask);
        chk("dual_ack_count", acks, 1);
        chk("dual_wen_cycle", wen_at, 2);
        chk("dual_rd_data_kept", core_rd_data, 5);
        chk("dual_mem12", mem[12], 9);

        // Read request while busy is dropped
        run_req(1'b1, 1'b0, 8'd5, 8'd0, 1'b1, ack_at, wen_at, acks, busy_mask);
        chk("busy_drop_ack_count", acks, 1);
        chk("busy_drop_ack_cycle", ack_at, 3);
        chk("busy_drop_rd_data", core_rd_data, 8);

        // Debug conflict: dbg_wen high for 3 cycles from the commit cycle
        core_wr_req = 1'b1;
        core_addr = 8'd11;
        core_wr_data = 8'd6;
        #1;
        cyc();
        core_wr_req = 1'b0;
        #1;
        chk("conf_c1_wen", mem_wen, 0);
        cyc();
        dbg_wen = 1'b1;
        dbg_write_addr = 8'd20;
        dbg_write_data = 8'h77;
        #1;
        chk("conf_c2_wen", mem_wen, 1);
        chk("conf_c2_waddr", mem_write_addr, 20);
        chk("conf_c2_ack", core_ack, 0);
        cyc();
        chk("conf_c3_ack", core_ack, 0);
        chk("conf_c3_busy", core_busy, 1);
        chk("conf_c3_waddr", mem_write_addr, 20);
        cyc();
        chk("conf_c4_ack", core_ack, 0);
        cyc();
        dbg_wen = 1'b0;
        #1;
        chk("conf_c5_wen", mem_wen, 1);
        chk("conf_c5_waddr", mem_write_addr, 11);
        chk("conf_c5_wdata", mem_write_data, 6);
        chk("conf_c5_ack", core_ack, 0);
        cyc();
        chk("conf_c6_ack", core_ack, 1);
`ifdef MEM_BUS_CTRL_STATS_EN
        chk("stat_stalls", stat_stalls, 3);
        chk("stat_writes", stat_writes, 2);
        chk("stat_reads", stat_reads, 3);
`endif
        cyc();
        chk("conf_c7_ack", core_ack, 0);
        chk("conf_c7_busy", core_busy, 0);
        chk("conf_mem11", mem[11], 6);
        chk("conf_mem20", mem[20], 8'h77);

        // Reset in the middle of a write
        core_wr_req = 1'b1;
        core_addr = 8'd13;
        core_wr_data = 8'h55;
        #1;
        cyc();
        core_wr_req = 1'b0;
        #1;
        chk("rstmid_busy_before", core_busy, 1);
        rst = 1'b0;
        #1;
        chk("rstmid_busy_in_rst", core_busy, 0);
        chk("rstmid_ack_in_rst", core_ack, 0);
        cyc();
        chk("rstmid_c2_wen", mem_wen, 0);
        chk("rstmid_c2_ack", core_ack, 0);
        chk("rstmid_c2_rd_data", core_rd_data, 0);
        rst = 1'b1;
        cyc();
        chk("rstmid_c3_wen", mem_wen, 0);
        chk("rstmid_c3_ack", core_ack, 0);
        chk("rstmid_c3_busy", core_busy, 0);
        chk("rstmid_mem13", mem[13], 0);
        run_req(1'b1, 1'b0, 8'd5, 8'd0, 1'b0, ack_at, wen_at, acks, busy_mask);
        chk("post_rst_ack_cycle", ack_at, 3);
        chk("post_rst_rd_data", core_rd_data, 8);
`ifdef MEM_BUS_CTRL_STATS_EN
        chk("post_rst_stat_reads", stat_reads, 1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
